// File: rtl/dmem_block.sv
// Block-addressed data memory behind the data cache, with a fixed-latency busywait handshake.
// Optional per-type access counters are enabled with DMEM_ACCESS_COUNT_EN.
module dmem_block #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              busywait
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [15:0]       read_count,
    output logic [15:0]       write_count
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              access;
    logic              op_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request with both read and write high is illegal and simply never accepted.
    always_comb begin
        state_next = state;
        busywait   = 1'b0;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (read ^ write) begin
                    busywait   = 1'b1;
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busywait = 1'b1;
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands are captured on acceptance so the requester may drop or change them while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            op_write <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            readdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                op_write <= write;
                lat_addr <= address;
                lat_data <= writedata;
                cnt      <= CNT_W'(LATENCY - 2);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (access) begin
                if (op_write) begin
                    mem[lat_addr] <= lat_data;
                end else begin
                    readdata <= mem[lat_addr];
                end
            end
        end
    end

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            read_count  <= '0;
            write_count <= '0;
        end else if (access) begin
            if (op_write) begin
                if (write_count != 16'hFFFF) begin
                    write_count <= write_count + 16'd1;
                end
            end else begin
                if (read_count != 16'hFFFF) begin
                    read_count <= read_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_block.sv
// Randomized bench for dmem_block: a LATENCY=5 and a LATENCY=2 instance checked against an array model.
// Counter ports are connected and checked when DMEM_ACCESS_COUNT_EN is defined.
module tb_dmem_block;

    logic        clk = 1'b0;
    logic        rst     [2];
    logic        rd_req  [2];
    logic        wr_req  [2];
    logic [5:0]  addr    [2];
    logic [31:0] wdata   [2];
    logic [31:0] rdata   [2];
    logic        bw      [2];
`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] rc      [2];
    logic [15:0] wc      [2];
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [2][64];
    logic [31:0] model_rd  [2];
    int          model_rc  [2];
    int          model_wc  [2];

    always #5 clk = ~clk;

    dmem_block #(.ADDR_W(6), .DATA_W(32), .LATENCY(5)) dut0 (
        .clk(clk), .reset(rst[0]), .read(rd_req[0]), .write(wr_req[0]),
        .address(addr[0]), .writedata(wdata[0]), .readdata(rdata[0]), .busywait(bw[0])
`ifdef DMEM_ACCESS_COUNT_EN
        , .read_count(rc[0]), .write_count(wc[0])
`endif
    );

    dmem_block #(.ADDR_W(6), .DATA_W(32), .LATENCY(2)) dut1 (
        .clk(clk), .reset(rst[1]), .read(rd_req[1]), .write(wr_req[1]),
        .address(addr[1]), .writedata(wdata[1]), .readdata(rdata[1]), .busywait(bw[1])
`ifdef DMEM_ACCESS_COUNT_EN
        , .read_count(rc[1]), .write_count(wc[1])
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic modelReset(input int d);
        for (int i = 0; i < 64; i++) model_mem[d][i] = 32'h0;
        model_rd[d] = 32'h0;
        model_rc[d] = 0;
        model_wc[d] = 0;
    endtask

    // One complete access; optionally drops the request and scrambles operands once it is accepted.
    task automatic applyStimulus(input int d, input logic w, input logic [5:0] a,
                                 input logic [31:0] data, input bit drop, input string tag);
        int busy;
        int lat;
        lat = (d == 0) ? 5 : 2;
        @(posedge clk);
        #1;
        rd_req[d] = ~w;
        wr_req[d] = w;
        addr[d]   = a;
        wdata[d]  = data;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bw[d]) break;
            busy++;
            if (drop && busy >= 2) begin
                rd_req[d] = 1'b0;
                wr_req[d] = 1'b0;
                addr[d]   = ~a;
                wdata[d]  = ~data;
            end
        end
        if (w) begin
            model_mem[d][a] = data;
            model_wc[d]++;
        end else begin
            model_rd[d] = model_mem[d][a];
            model_rc[d]++;
        end
        checkOutput({tag, " busy"}, busy, lat);
        checkOutput({tag, " rdata"}, rdata[d], model_rd[d]);
        rd_req[d] = 1'b0;
        wr_req[d] = 1'b0;
    endtask

    initial begin
        logic [5:0]  ra;
        logic [31:0] rdat;
        bit          rw;
        bit          rdrop;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rd_req[d] = 1'b0; wr_req[d] = 1'b0;
            addr[d] = 6'h0; wdata[d] = 32'h0;
            modelReset(d);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset busywait", {31'b0, bw[d]}, 32'h0);
            checkOutput("reset rdata", rdata[d], 32'h0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        applyStimulus(0, 1'b0, 6'h00, 32'h0, 1'b0, "t1 read0");
        applyStimulus(0, 1'b1, 6'h2A, 32'hDEADBEEF, 1'b0, "t2 write");
        applyStimulus(0, 1'b0, 6'h2A, 32'h0, 1'b0, "t2 read");
        applyStimulus(0, 1'b1, 6'h11, 32'h01020304, 1'b0, "t3 wb");
        applyStimulus(0, 1'b0, 6'h31, 32'h0, 1'b0, "t3 fill");
        applyStimulus(0, 1'b0, 6'h11, 32'h0, 1'b0, "t3 readback");

        // Illegal simultaneous read and write must be ignored.
        @(posedge clk);
        #1;
        rd_req[0] = 1'b1; wr_req[0] = 1'b1; addr[0] = 6'h2A; wdata[0] = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t4 illegal busywait", {31'b0, bw[0]}, 32'h0);
        end
        checkOutput("t4 illegal rdata", rdata[0], model_rd[0]);
        rd_req[0] = 1'b0; wr_req[0] = 1'b0;
        applyStimulus(0, 1'b0, 6'h2A, 32'h0, 1'b0, "t4 mem kept");
        applyStimulus(0, 1'b1, 6'h3C, 32'hCAFEF00D, 1'b0, "t4 write");
        applyStimulus(0, 1'b0, 6'h3C, 32'h0, 1'b0, "t4 read");

        // Reset in the middle of a write aborts it.
        @(posedge clk);
        #1;
        wr_req[0] = 1'b1; addr[0] = 6'h05; wdata[0] = 32'hA5A5A5A5;
        repeat (3) @(negedge clk);
        checkOutput("t5 busy before reset", {31'b0, bw[0]}, 32'h1);
        rst[0] = 1'b1; wr_req[0] = 1'b0;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        modelReset(0);
        @(negedge clk);
        checkOutput("t5 busywait", {31'b0, bw[0]}, 32'h0);
        checkOutput("t5 rdata", rdata[0], 32'h0);
        applyStimulus(0, 1'b0, 6'h05, 32'h0, 1'b0, "t5 mem05");
        applyStimulus(0, 1'b0, 6'h2A, 32'h0, 1'b0, "t5 mem2A");

        for (int n = 0; n < 40; n++) begin
            ra    = 6'($urandom_range(0, 7));
            rdat  = $urandom;
            rw    = 1'($urandom_range(0, 1));
            rdrop = 1'($urandom_range(0, 1));
            applyStimulus(0, rw, ra, rdat, rdrop, "rand lat5");
        end

        applyStimulus(1, 1'b1, 6'h07, 32'h0000AA55, 1'b0, "t6 write");
        applyStimulus(1, 1'b0, 6'h07, 32'h0, 1'b0, "t6 read07");
        applyStimulus(1, 1'b0, 6'h00, 32'h0, 1'b0, "t6 read00");
        applyStimulus(1, 1'b0, 6'h07, 32'h0, 1'b1, "t6 read drop");
        for (int n = 0; n < 16; n++) begin
            ra    = 6'($urandom_range(0, 3));
            rdat  = $urandom;
            rw    = 1'($urandom_range(0, 1));
            rdrop = 1'($urandom_range(0, 1));
            applyStimulus(1, rw, ra, rdat, rdrop, "rand lat2");
        end

`ifdef DMEM_ACCESS_COUNT_EN
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("read_count", {16'h0, rc[d]}, 32'(model_rc[d]));
            checkOutput("write_count", {16'h0, wc[d]}, 32'(model_wc[d]));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
